// File: rtl/bitty_ctrl_pkg.sv
// Shared types and codes for the bitty instruction sequencer.
package bitty_ctrl_pkg;

   // Sequencer states. The encoding is fixed so the debug port reads predictably.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      MEM   = 2'd2,
      STORE = 2'd3
   } state_t;

   // Instruction format codes, instruction[1:0]
   localparam logic [1:0] FMT_RR  = 2'b00;  // reg-reg ALU
   localparam logic [1:0] FMT_RI  = 2'b01;  // reg-imm ALU
   localparam logic [1:0] FMT_NOP = 2'b10;  // no operands, no writeback
   localparam logic [1:0] FMT_LS  = 2'b11;  // load (ls_flag=0) / store (ls_flag=1)

   // Operand mux codes that do not select a register
   localparam logic [3:0] MUXSEL_IMM  = 4'b1000;
   localparam logic [3:0] MUXSEL_NONE = 4'b1001;

   // Load/store unit request codes
   localparam logic [1:0] LS_IDLE  = 2'b00;
   localparam logic [1:0] LS_LOAD  = 2'b01;
   localparam logic [1:0] LS_STORE = 2'b10;

endpackage

// File: rtl/bitty_ls_timer.sv
// Wait counter for the load/store phase. Cleared while i_clear is high,
// counts while i_en is high, and flags the last allowed cycle on o_expire.
// LS_TIMEOUT == 0 means the wait is unbounded, so o_expire never fires.
module bitty_ls_timer #(
   parameter int LS_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = (LS_TIMEOUT > 0) ? $clog2(LS_TIMEOUT + 1) : 1;

   logic [CW-1:0] r_count;

   // Count enabled cycles; reset and clear both return the count to zero
   always_ff @(posedge clk) begin
      if (!reset || i_clear) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + CW'(1);
      end
   end

   // Expire on the final permitted wait cycle (count == LS_TIMEOUT-1)
   assign o_expire = (LS_TIMEOUT != 0) && i_en && (r_count == CW'(LS_TIMEOUT - 1));

endmodule

// File: rtl/bitty_seq_ctrl.sv
// Multi-cycle instruction sequencer for the bitty datapath.
// Flow: IDLE -> FETCH -> (MEM) -> STORE -> IDLE; no-op format goes IDLE -> STORE.
// Handshake: run is only sampled in IDLE; the instruction is latched on that
// same edge and later changes on the instruction input are ignored. In MEM,
// en_ls is held until ls_done is seen high at a clock edge (or the wait
// times out); ls_done outside MEM has no effect.
module bitty_seq_ctrl
   import bitty_ctrl_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int NREGS      = 8,
   parameter int IMM_SIGNED = 0,
   parameter int LS_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [15:0]       instruction,
   input  logic              ls_done,
   output logic [3:0]        mux_sel,
   output logic [2:0]        sel,
   output logic              sel_reg_c,
   output logic              en_s,
   output logic              en_c,
   output logic [1:0]        en_ls,
   output logic [NREGS-1:0]  en,
   output logic              en_inst,
   output logic [DATA_W-1:0] immediate,
   output logic              done,
   output logic              busy,
   output logic              ls_err,
   output state_t            o_dbg_state
);

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_ir;
   logic        r_ls_err;
   logic        w_expire;
   logic [7:0]  w_en_onehot;

   // Live fields (IDLE decode) and latched fields (all later states)
   logic [2:0] w_live_rx;
   logic [1:0] w_live_fmt;
   logic [2:0] w_rx;
   logic [2:0] w_ry;
   logic [7:0] w_imm8;
   logic [1:0] w_fmt;
   logic       w_ls_flag;

   assign w_live_rx  = instruction[15:13];
   assign w_live_fmt = instruction[1:0];
   assign w_rx       = r_ir[15:13];
   assign w_ry       = r_ir[12:10];
   assign w_imm8     = r_ir[12:5];
   assign w_fmt      = r_ir[1:0];
   assign w_ls_flag  = r_ir[2];

   bitty_ls_timer #(
      .LS_TIMEOUT(LS_TIMEOUT)
   ) u_ls_timer (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (r_state != MEM),
      .i_en     (r_state == MEM),
      .o_expire (w_expire)
   );

   // State, instruction register and sticky timeout flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_ir     <= '0;
         r_ls_err <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == IDLE && run) begin
            r_ir     <= instruction;
            r_ls_err <= 1'b0;
         end else if (r_state == MEM && !ls_done && w_expire) begin
            r_ls_err <= 1'b1;
         end
      end
   end

   // Next-state decode; ls_done takes priority over a same-cycle timeout
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (run) begin
               w_next_state = (w_live_fmt == FMT_NOP) ? STORE : FETCH;
            end
         end
         FETCH:   w_next_state = (w_fmt == FMT_LS) ? MEM : STORE;
         MEM: begin
            if (ls_done || w_expire) begin
               w_next_state = STORE;
            end
         end
         STORE:   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Decode rx to one bit per register; bits at or above NREGS are discarded
   assign w_en_onehot = 8'b1 << w_rx;

   // Moore output decode from state and ir; IDLE operand select follows live input
   always_comb begin
      mux_sel   = MUXSEL_NONE;
      sel       = 3'd0;
      sel_reg_c = 1'b0;
      en_s      = 1'b0;
      en_c      = 1'b0;
      en_ls     = LS_IDLE;
      en        = '0;
      en_inst   = 1'b0;
      done      = 1'b0;
      case (r_state)
         IDLE: begin
            en_inst = 1'b1;
            if (run && w_live_fmt != FMT_NOP) begin
               en_s    = 1'b1;
               mux_sel = {1'b0, w_live_rx};
            end
         end
         FETCH: begin
            en_c = 1'b1;
            sel  = r_ir[4:2];
            if (w_fmt == FMT_RI) begin
               mux_sel = MUXSEL_IMM;
            end else if (w_fmt == FMT_RR || w_fmt == FMT_LS) begin
               mux_sel = {1'b0, w_ry};
            end
            sel_reg_c = (w_fmt == FMT_LS);
         end
         MEM: begin
            en_ls     = w_ls_flag ? LS_STORE : LS_LOAD;
            sel_reg_c = 1'b1;
         end
         STORE: begin
            done = 1'b1;
            if (w_fmt == FMT_RR || w_fmt == FMT_RI ||
                (w_fmt == FMT_LS && !w_ls_flag && !r_ls_err)) begin
               en = w_en_onehot[NREGS-1:0];
            end
         end
         default: ;
      endcase
   end

   assign immediate   = (IMM_SIGNED != 0) ? DATA_W'($signed(w_imm8)) : DATA_W'(w_imm8);
   assign busy        = (r_state != IDLE);
   assign ls_err      = r_ls_err;
   assign o_dbg_state = r_state;

endmodule
